// File: rtl/pipelined_subtractor.sv
// Chunked, pipelined unsigned subtractor: a - b - bin over SIZE bits, one CHUNK slice per stage,
// valid/ready handshake with global stall. Define SUBTRACTOR_OVERFLOW_EN for a registered signed-overflow flag.
module pipelined_subtractor #(
  parameter int SIZE   = 16,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] d,
  output logic            bout,
  output logic            ovf
);

  localparam int CHUNK = SIZE / STAGES;

  logic stall;
  logic advance;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign advance  = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    // Stage k sees the not-yet-consumed upper slices of a/b and the finished lower slices of d.
    localparam int IN_W  = SIZE - k * CHUNK;
    localparam int OUT_W = (k + 1) * CHUNK;

    logic [IN_W-1:0]  aIn;
    logic [IN_W-1:0]  bIn;
    logic             borrowIn;
    logic             validIn;
    logic [CHUNK:0]   diff;
    logic [OUT_W-1:0] dSkew_d;
    logic [OUT_W-1:0] dSkew_q;
    logic             borrow_d;
    logic             borrow_q;
    logic             valid_q;

    if (k == 0) begin : gFirst
      assign aIn      = a;
      assign bIn      = b;
      assign borrowIn = bin;
      assign validIn  = in_valid;
      assign dSkew_d  = diff[CHUNK-1:0];
    end else begin : gNext
      assign aIn      = gStage[k-1].gSkew.aSkew_q;
      assign bIn      = gStage[k-1].gSkew.bSkew_q;
      assign borrowIn = gStage[k-1].borrow_q;
      assign validIn  = gStage[k-1].valid_q;
      assign dSkew_d  = {diff[CHUNK-1:0], gStage[k-1].dSkew_q};
    end

    // The extra top bit of the widened difference is set exactly when the slice borrows.
    assign diff     = {1'b0, aIn[CHUNK-1:0]} - {1'b0, bIn[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrowIn};
    assign borrow_d = diff[CHUNK];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q  <= 1'b0;
        borrow_q <= 1'b0;
        dSkew_q  <= '0;
      end else if (advance) begin
        valid_q <= validIn;
        if (validIn) begin
          borrow_q <= borrow_d;
          dSkew_q  <= dSkew_d;
        end
      end
    end

    if (k < STAGES - 1) begin : gSkew
      logic [IN_W-CHUNK-1:0] aSkew_q;
      logic [IN_W-CHUNK-1:0] bSkew_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          aSkew_q <= '0;
          bSkew_q <= '0;
        end else if (advance && validIn) begin
          aSkew_q <= aIn[IN_W-1:CHUNK];
          bSkew_q <= bIn[IN_W-1:CHUNK];
        end
      end
    end
  end

  assign out_valid = gStage[STAGES-1].valid_q;
  assign d         = gStage[STAGES-1].dSkew_q;
  assign bout      = gStage[STAGES-1].borrow_q;

`ifdef SUBTRACTOR_OVERFLOW_EN
  // The last slice still carries the operand sign bits, so overflow is resolved there.
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (gStage[STAGES-1].aIn[CHUNK-1] != gStage[STAGES-1].bIn[CHUNK-1]) &&
                 (gStage[STAGES-1].diff[CHUNK-1] != gStage[STAGES-1].aIn[CHUNK-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (advance && gStage[STAGES-1].validIn) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor: queue-based reference model plus directed
// latency, borrow-ripple, back-pressure, overflow and async-reset scenarios.
module tb_pipelined_subtractor;

  localparam int SIZE   = 16;
  localparam int STAGES = 4;
`ifdef SUBTRACTOR_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            bin;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] d;
  logic            bout;
  logic            ovf;

  int checkCount = 0;
  int failCount  = 0;
  int cycleCount = 0;
  int outCount   = 0;
  logic bpMode   = 1'b0;

  logic [17:0] expQ[$];
  logic        prevStall = 1'b0;
  logic [15:0] prevD;
  logic        prevBout;
  logic        prevOvf;

  int          capN;
  int          capCyc[8];
  logic [15:0] capD[8];
  logic        capB[8];
  logic        capO[8];

  pipelined_subtractor #(.SIZE(SIZE), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, bout, d} straight from integer arithmetic on the operands.
  function automatic logic [17:0] refModel(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    logic [16:0] diffV;
    logic        ov;
    diffV = {1'b0, av} - {1'b0, bv} - {16'd0, bi};
`ifdef SUBTRACTOR_OVERFLOW_EN
    begin
      int sa;
      sa = int'($signed(av)) - int'($signed(bv)) - int'(bi);
      ov = (sa < -32768) || (sa > 32767);
    end
`else
    ov = 1'b0;
`endif
    return {ov, diffV};
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] expV);
    checkCount++;
    if (act !== expV) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, expV, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall = 1'b0;
    end else begin
      cycleCount++;
      if (prevStall) begin
        checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("hold_data", {14'd0, ovf, bout, d}, {14'd0, prevOvf, prevBout, prevD});
      end
      if (out_valid && !out_ready) checkOutput("in_ready_stall", {31'd0, in_ready}, 32'd0);
      if (!out_valid) checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkCount++;
          failCount++;
          $display("[TB] FAIL unexpected_output: got d=%h bout=%b, expected no result (t=%0t)", d, bout, $time);
        end else begin
          logic [17:0] expV;
          expV = expQ.pop_front();
          checkOutput("result", {15'd0, bout, d}, {15'd0, expV[16:0]});
          checkOutput("ovf", {31'd0, ovf}, {31'd0, expV[17]});
          outCount++;
        end
      end
      if (in_valid && in_ready) expQ.push_back(refModel(a, b, bin));
      prevStall = out_valid && !out_ready;
      prevD     = d;
      prevBout  = bout;
      prevOvf   = ovf;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bpMode) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Presents one beat and returns one tick after the edge that accepted it.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    int waitCycles = 0;
    a = av;
    b = bv;
    bin = bi;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitCycles < 200) begin
      tick();
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL accept_timeout: in_ready=%b, expected 1 within 200 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("drain", expQ.size(), 32'd0);
  endtask

  task automatic captureOutputs(input int cycles);
    capN = 0;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (out_valid && capN < 8) begin
        capCyc[capN] = i;
        capD[capN]   = d;
        capB[capN]   = bout;
        capO[capN]   = ovf;
        capN++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startCyc;
    int startOut;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_d", {16'd0, d}, 32'd0);
    checkOutput("reset_bout", {31'd0, bout}, 32'd0);
    checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat: result appears exactly STAGES cycles after presentation, nowhere else.
    applyStimulus(16'h1234, 16'h0234, 1'b0);
    captureOutputs(10);
    checkOutput("lat_count", capN, 32'd1);
    checkOutput("lat_cycle", capCyc[0], 32'd4);
    checkOutput("lat_d", {16'd0, capD[0]}, 32'h1000);
    checkOutput("lat_bout", {31'd0, capB[0]}, 32'd0);

    // Borrow rippling through every slice, back to back.
    applyStimulus(16'h0000, 16'h0000, 1'b1);
    applyStimulus(16'h0000, 16'h0001, 1'b0);
    captureOutputs(10);
    checkOutput("ripple_count", capN, 32'd2);
    checkOutput("ripple_b2b", capCyc[1] - capCyc[0], 32'd1);
    checkOutput("ripple_d0", {16'd0, capD[0]}, 32'hFFFF);
    checkOutput("ripple_b0", {31'd0, capB[0]}, 32'd1);
    checkOutput("ripple_d1", {16'd0, capD[1]}, 32'hFFFF);
    checkOutput("ripple_b1", {31'd0, capB[1]}, 32'd1);

    // Full-rate streaming.
    startCyc = cycleCount;
    startOut = outCount;
    for (int i = 0; i < 64; i++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    waitDrain();
    checkOutput("stream_count", outCount - startOut, 32'd64);
    checkOutput("stream_rate", {31'd0, ((cycleCount - startCyc) <= 64 + STAGES + 1)}, 32'd1);

    // Back-pressure with random out_ready.
    bpMode = 1'b1;
    startOut = outCount;
    for (int i = 0; i < 10; i++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    waitDrain();
    bpMode = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_count", outCount - startOut, 32'd10);
    tick();

    // Signed overflow corner cases.
    applyStimulus(16'h8000, 16'h0001, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    captureOutputs(10);
    checkOutput("ovf_count", capN, 32'd2);
    checkOutput("ovf_d0", {16'd0, capD[0]}, 32'h7FFF);
    checkOutput("ovf_flag0", {31'd0, capO[0]}, {31'd0, OVF_EN});
    checkOutput("ovf_d1", {16'd0, capD[1]}, 32'h7FFE);
    checkOutput("ovf_flag1", {31'd0, capO[1]}, 32'd0);

    // Asynchronous reset with three beats in flight.
    for (int i = 0; i < 3; i++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    #1;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_d", {16'd0, d}, 32'd0);
    checkOutput("async_bout", {31'd0, bout}, 32'd0);
    checkOutput("async_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    applyStimulus(16'h0005, 16'h0007, 1'b0);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
